// File: rtl/video_mono_filter_pkg.sv
// Shared encodings and default luma weights for the monochrome video filter.
package video_mono_filter_pkg;

  // Requested/applied tint modes; codes 5-7 fall back to colour pass-through.
  localparam logic [2:0] MODE_COLOUR  = 3'd0;
  localparam logic [2:0] MODE_GREEN   = 3'd1;
  localparam logic [2:0] MODE_AMBER   = 3'd2;
  localparam logic [2:0] MODE_GREY    = 3'd3;
  localparam logic [2:0] MODE_REVERSE = 3'd4;

  // Rec.709 luma weights in /256 fixed point, and the default channel width.
  localparam int DEF_CW = 6;
  localparam int DEF_WR = 54;
  localparam int DEF_WG = 183;
  localparam int DEF_WB = 19;

endpackage

// File: rtl/video_mono_filter_luma.sv
// Two-stage luma pipeline: weighted products, then rounded/saturated sum.
// Colour and sync sideband ride along so everything stays pixel-aligned.
module video_mono_filter_luma
  import video_mono_filter_pkg::*;
#(
  parameter int   CW     = DEF_CW,
  parameter int   WR     = DEF_WR,
  parameter int   WG     = DEF_WG,
  parameter int   WB     = DEF_WB,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          de_in,
  output logic [CW-1:0] y_p2,
  output logic [CW-1:0] r_p2,
  output logic [CW-1:0] g_p2,
  output logic [CW-1:0] b_p2,
  output logic          de_p2,
  output logic          hs_p1,
  output logic          vs_p1,
  output logic          hs_p2,
  output logic          vs_p2
);

  localparam int          PW   = CW + 8;
  localparam int          SW   = CW + 10;
  localparam logic [CW-1:0] MAXV = '1;

  // Round to nearest on the /256 scale.
  function automatic logic [SW-1:0] round_q8(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s + SW'(128);
    return t >> 8;
  endfunction

  // Clamp to the channel range in case the weights sum above 256.
  function automatic logic [CW-1:0] sat_cw(input logic [SW-1:0] v);
    if (v > SW'(MAXV)) return MAXV;
    return v[CW-1:0];
  endfunction

  logic [PW-1:0] pr_p1_d, pr_p1_q, pg_p1_d, pg_p1_q, pb_p1_d, pb_p1_q;
  logic [CW-1:0] r_p1_q, g_p1_q, b_p1_q;
  logic          de_p1_q, hs_p1_q, vs_p1_q;
  logic [SW-1:0] sum_p2;
  logic [CW-1:0] y_p2_d, y_p2_q, r_p2_q, g_p2_q, b_p2_q;
  logic          de_p2_q, hs_p2_q, vs_p2_q;

  // S1 products.
  always_comb begin
    pr_p1_d = PW'(r_in) * PW'(WR);
    pg_p1_d = PW'(g_in) * PW'(WG);
    pb_p1_d = PW'(b_in) * PW'(WB);
  end

  // S1 registers: products plus delayed colour and sideband.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      pr_p1_q <= '0;
      pg_p1_q <= '0;
      pb_p1_q <= '0;
      r_p1_q  <= '0;
      g_p1_q  <= '0;
      b_p1_q  <= '0;
      de_p1_q <= 1'b0;
      hs_p1_q <= ~HS_POL;
      vs_p1_q <= ~VS_POL;
    end else begin
      pr_p1_q <= pr_p1_d;
      pg_p1_q <= pg_p1_d;
      pb_p1_q <= pb_p1_d;
      r_p1_q  <= r_in;
      g_p1_q  <= g_in;
      b_p1_q  <= b_in;
      de_p1_q <= de_in;
      hs_p1_q <= hs_in;
      vs_p1_q <= vs_in;
    end
  end

  // S2 sum, round and saturate.
  always_comb begin
    sum_p2 = SW'(pr_p1_q) + SW'(pg_p1_q) + SW'(pb_p1_q);
    y_p2_d = sat_cw(round_q8(sum_p2));
  end

  // S2 registers: luma plus delayed colour and sideband.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      y_p2_q  <= '0;
      r_p2_q  <= '0;
      g_p2_q  <= '0;
      b_p2_q  <= '0;
      de_p2_q <= 1'b0;
      hs_p2_q <= ~HS_POL;
      vs_p2_q <= ~VS_POL;
    end else begin
      y_p2_q  <= y_p2_d;
      r_p2_q  <= r_p1_q;
      g_p2_q  <= g_p1_q;
      b_p2_q  <= b_p1_q;
      de_p2_q <= de_p1_q;
      hs_p2_q <= hs_p1_q;
      vs_p2_q <= vs_p1_q;
    end
  end

  assign y_p2  = y_p2_q;
  assign r_p2  = r_p2_q;
  assign g_p2  = g_p2_q;
  assign b_p2  = b_p2_q;
  assign de_p2 = de_p2_q;
  assign hs_p1 = hs_p1_q;
  assign vs_p1 = vs_p1_q;
  assign hs_p2 = hs_p2_q;
  assign vs_p2 = vs_p2_q;

endmodule

// File: rtl/video_mono_filter.sv
// Colour-to-monochrome post-processor: luma, tint, scanline dim, blanking.
// Mode is latched on vsync leading edges so a frame never changes tint mid-way.
module video_mono_filter
  import video_mono_filter_pkg::*;
#(
  parameter int   CW     = DEF_CW,
  parameter int   WR     = DEF_WR,
  parameter int   WG     = DEF_WG,
  parameter int   WB     = DEF_WB,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic          clk_vga,
  input  logic          rst_n,
  input  logic [2:0]    mode_in,
  input  logic          scan_en,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          de_in,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic [3:0]    mode_act
);

  localparam logic [CW-1:0] MAXV = '1;

  logic [CW-1:0] y_p2, r_p2, g_p2, b_p2;
  logic          de_p2, hs_p1, vs_p1, hs_p2, vs_p2;
  logic          hs_lead, vs_lead;
  logic [3:0]    mode_d, mode_q;
  logic          par_d, par_q;
  logic [CW-1:0] tr, tg, tb;
  logic [CW-1:0] r_p3_d, r_p3_q, g_p3_d, g_p3_q, b_p3_d, b_p3_q;
  logic          hs_p3_d, hs_p3_q, vs_p3_d, vs_p3_q;

  video_mono_filter_luma #(
    .CW(CW), .WR(WR), .WG(WG), .WB(WB), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_luma (
    .clk_vga(clk_vga), .rst_n(rst_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .y_p2(y_p2), .r_p2(r_p2), .g_p2(g_p2), .b_p2(b_p2), .de_p2(de_p2),
    .hs_p1(hs_p1), .vs_p1(vs_p1), .hs_p2(hs_p2), .vs_p2(vs_p2)
  );

  // Frame/line tracking on S1 syncs; S2 copy serves as the previous sample.
  always_comb begin
    hs_lead = (hs_p1 == HS_POL) && (hs_p2 != HS_POL);
    vs_lead = (vs_p1 == VS_POL) && (vs_p2 != VS_POL);
    mode_d  = mode_q;
    par_d   = par_q;
    if (vs_lead) begin
      mode_d = {scan_en, mode_in};
      par_d  = 1'b0;
    end else if (hs_lead) begin
      par_d  = ~par_q;
    end
  end

  // Mode latch and line parity.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      mode_q <= '0;
      par_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      par_q  <= par_d;
    end
  end

  // S3 tint, scanline dim and blanking.
  always_comb begin
    tr = r_p2;
    tg = g_p2;
    tb = b_p2;
    case (mode_q[2:0])
      MODE_GREEN:   begin tr = '0;          tg = y_p2;        tb = '0;          end
      MODE_AMBER:   begin tr = y_p2;        tg = y_p2 >> 1;   tb = '0;          end
      MODE_GREY:    begin tr = y_p2;        tg = y_p2;        tb = y_p2;        end
      MODE_REVERSE: begin tr = MAXV - y_p2; tg = MAXV - y_p2; tb = MAXV - y_p2; end
      default: ;
    endcase
    if (mode_q[3] && par_q) begin
      tr = tr >> 1;
      tg = tg >> 1;
      tb = tb >> 1;
    end
    if (!de_p2) begin
      tr = '0;
      tg = '0;
      tb = '0;
    end
    r_p3_d  = tr;
    g_p3_d  = tg;
    b_p3_d  = tb;
    hs_p3_d = hs_p2;
    vs_p3_d = vs_p2;
  end

  // S3 output registers.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_p3_q  <= '0;
      g_p3_q  <= '0;
      b_p3_q  <= '0;
      hs_p3_q <= ~HS_POL;
      vs_p3_q <= ~VS_POL;
    end else begin
      r_p3_q  <= r_p3_d;
      g_p3_q  <= g_p3_d;
      b_p3_q  <= b_p3_d;
      hs_p3_q <= hs_p3_d;
      vs_p3_q <= vs_p3_d;
    end
  end

  assign r_out    = r_p3_q;
  assign g_out    = g_p3_q;
  assign b_out    = b_p3_q;
  assign hs_out   = hs_p3_q;
  assign vs_out   = vs_p3_q;
  assign mode_act = mode_q;

endmodule

// File: tb/tb_video_mono_filter.sv
// Bench for video_mono_filter: two instances (active-low and active-high syncs)
// driven from the same stimulus, checked against a sequence-level model.
module tb_video_mono_filter;

  localparam int CW    = 6;
  localparam int M     = 63;
  localparam int WR    = 54;
  localparam int WG    = 183;
  localparam int WB    = 19;
  localparam int L_MAX = 700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [2:0]    mode_in;
  logic          scan_en;
  logic [CW-1:0] r_in, g_in, b_in;
  logic          hs_a, vs_a, de_in;
  logic          hs_n, vs_n;
  assign hs_n = ~hs_a;
  assign vs_n = ~vs_a;

  logic [CW-1:0] r0, g0, b0, r1, g1, b1;
  logic          hs0, vs0, hs1, vs1;
  logic [3:0]    m0, m1;

  video_mono_filter #(.CW(CW), .WR(WR), .WG(WG), .WB(WB), .HS_POL(1'b0), .VS_POL(1'b0)) u_dut (
    .clk_vga(clk), .rst_n(rst_n), .mode_in(mode_in), .scan_en(scan_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_n), .vs_in(vs_n), .de_in(de_in),
    .r_out(r0), .g_out(g0), .b_out(b0), .hs_out(hs0), .vs_out(vs0), .mode_act(m0)
  );

  video_mono_filter #(.CW(CW), .WR(WR), .WG(WG), .WB(WB), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut_p (
    .clk_vga(clk), .rst_n(rst_n), .mode_in(mode_in), .scan_en(scan_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_a), .vs_in(vs_a), .de_in(de_in),
    .r_out(r1), .g_out(g1), .b_out(b1), .hs_out(hs1), .vs_out(vs1), .mode_act(m1)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0]  st_r [L_MAX];
  logic [5:0]  st_g [L_MAX];
  logic [5:0]  st_b [L_MAX];
  logic        st_de [L_MAX];
  logic        st_hs [L_MAX];
  logic        st_vs [L_MAX];
  logic [2:0]  st_m [L_MAX];
  logic        st_s [L_MAX];
  logic [17:0] ex_rgb [L_MAX];
  logic [3:0]  ex_ma [L_MAX];

  int tc [10][7] = '{
    '{3, 63,  0,  0, 13, 13, 13},
    '{3,  0, 63,  0, 45, 45, 45},
    '{2, 63, 63, 63, 63, 31,  0},
    '{1, 63, 63, 63,  0, 63,  0},
    '{4, 63, 63, 63,  0,  0,  0},
    '{0, 63, 63, 63, 63, 63, 63},
    '{5, 63, 63, 63, 63, 63, 63},
    '{4, 63,  0,  0, 50, 50, 50},
    '{2,  0, 63,  0, 45, 22,  0},
    '{7, 10, 20, 30, 10, 20, 30}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hs/vs are given as "active" flags; each instance sees its own polarity.
  task automatic drive(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                       input logic de, input logic hs, input logic vs,
                       input logic [2:0] m, input logic s);
    r_in = r; g_in = g; b_in = b; de_in = de; hs_a = hs; vs_a = vs;
    mode_in = m; scan_en = s;
  endtask

  task automatic load_mode(input logic [2:0] m, input logic s);
    drive(0, 0, 0, 0, 0, 1, m, s); step();
    drive(0, 0, 0, 0, 0, 0, m, s); step(); step(); step();
  endtask

  task automatic pix_through(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                             input logic [2:0] m, input logic s);
    drive(r, g, b, 1, 0, 0, m, s); step();
    drive(0, 0, 0, 0, 0, 0, m, s); step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(6'($urandom), 6'($urandom), 6'($urandom), 1, 1, 1, 3'd3, 1'b1);
    step(); step();
    n_cmp++; if ({r0, g0, b0} !== 18'd0) begin n_err++; $display("FAIL reset_rgb0 got=%h exp=0", {r0, g0, b0}); end
    n_cmp++; if ({r1, g1, b1} !== 18'd0) begin n_err++; $display("FAIL reset_rgb1 got=%h exp=0", {r1, g1, b1}); end
    n_cmp++; if ({hs0, vs0} !== 2'b11) begin n_err++; $display("FAIL reset_sync0 got=%b exp=11", {hs0, vs0}); end
    n_cmp++; if ({hs1, vs1} !== 2'b00) begin n_err++; $display("FAIL reset_sync1 got=%b exp=00", {hs1, vs1}); end
    n_cmp++; if (m0 !== 4'd0 || m1 !== 4'd0) begin n_err++; $display("FAIL reset_mode got=%h/%h exp=0", m0, m1); end
    rst_n = 1'b1;
  endtask

  task automatic test_tints();
    logic [17:0] e;
    logic [2:0]  md;
    for (int i = 0; i < 10; i++) begin
      md = 3'(tc[i][0]);
      e  = {6'(tc[i][4]), 6'(tc[i][5]), 6'(tc[i][6])};
      load_mode(md, 1'b0);
      n_cmp++; if (m0 !== {1'b0, md} || m1 !== {1'b0, md}) begin
        n_err++; $display("FAIL tint_mode case=%0d got=%h/%h exp=%h", i, m0, m1, {1'b0, md}); end
      pix_through(6'(tc[i][1]), 6'(tc[i][2]), 6'(tc[i][3]), md, 1'b0);
      n_cmp++; if ({r0, g0, b0} !== e) begin n_err++; $display("FAIL tint_rgb0 case=%0d got=%h exp=%h", i, {r0, g0, b0}, e); end
      n_cmp++; if ({r1, g1, b1} !== e) begin n_err++; $display("FAIL tint_rgb1 case=%0d got=%h exp=%h", i, {r1, g1, b1}, e); end
    end
  endtask

  task automatic test_mode_midframe();
    load_mode(3'd0, 1'b0);
    drive(63, 0, 0, 1, 0, 0, 3'd3, 1'b0); step();
    n_cmp++; if (m0 !== 4'd0) begin n_err++; $display("FAIL midframe_hold got=%h exp=0", m0); end
    drive(0, 63, 0, 1, 0, 1, 3'd3, 1'b0); step();
    drive(0, 0, 0, 0, 0, 0, 3'd3, 1'b0); step();
    n_cmp++; if ({r0, g0, b0} !== {6'd63, 6'd0, 6'd0}) begin
      n_err++; $display("FAIL midframe_colour got=%h exp=%h", {r0, g0, b0}, {6'd63, 6'd0, 6'd0}); end
    n_cmp++; if (m0 !== 4'd3 || m1 !== 4'd3) begin n_err++; $display("FAIL midframe_load got=%h/%h exp=3", m0, m1); end
    step();
    n_cmp++; if ({r0, g0, b0} !== {6'd45, 6'd45, 6'd45}) begin
      n_err++; $display("FAIL midframe_grey got=%h exp=%h", {r0, g0, b0}, {6'd45, 6'd45, 6'd45}); end
  endtask

  task automatic test_reset_midline();
    load_mode(3'd3, 1'b1);
    drive(63, 63, 63, 1, 1, 0, 3'd3, 1'b1); step();
    drive(63, 63, 63, 1, 0, 0, 3'd3, 1'b1); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_cmp++; if ({r0, g0, b0, r1, g1, b1} !== 36'd0) begin
      n_err++; $display("FAIL rstmid_rgb got=%h/%h exp=0", {r0, g0, b0}, {r1, g1, b1}); end
    n_cmp++; if ({hs0, vs0, hs1, vs1} !== 4'b1100) begin
      n_err++; $display("FAIL rstmid_sync got=%b exp=1100", {hs0, vs0, hs1, vs1}); end
    n_cmp++; if (m0 !== 4'd0 || m1 !== 4'd0) begin n_err++; $display("FAIL rstmid_mode got=%h/%h exp=0", m0, m1); end
    pix_through(63, 63, 63, 3'd3, 1'b1);
    n_cmp++; if ({r0, g0, b0} !== {6'd63, 6'd63, 6'd63} || m0 !== 4'd0) begin
      n_err++; $display("FAIL rstmid_colour got=%h mode=%h exp=fff_fff mode=0", {r0, g0, b0}, m0); end
    load_mode(3'd2, 1'b1);
    n_cmp++; if (m0 !== 4'hA) begin n_err++; $display("FAIL rstmid_recover_mode got=%h exp=a", m0); end
    pix_through(63, 63, 63, 3'd2, 1'b1);
    n_cmp++; if ({r0, g0, b0} !== {6'd63, 6'd31, 6'd0}) begin
      n_err++; $display("FAIL rstmid_recover_rgb got=%h exp=%h", {r0, g0, b0}, {6'd63, 6'd31, 6'd0}); end
  endtask

  // Reference: walk the sample sequence with the frame/line rules, then
  // drive it after a reset and compare each pixel three edges later.
  task automatic run_stream(input string name, input int len);
    logic ph, pv, sc, par;
    logic [2:0] md;
    int nx, y, er, eg, eb;
    ph = 0; pv = 0; md = 0; sc = 0; par = 0;
    for (int c = 0; c < len; c++) begin
      nx = (c + 1 < len) ? c + 1 : c;
      if (st_vs[c] && !pv) begin md = st_m[nx]; sc = st_s[nx]; par = 0; end
      else if (st_hs[c] && !ph) par = !par;
      ph = st_hs[c]; pv = st_vs[c];
      y = (int'(st_r[c]) * WR + int'(st_g[c]) * WG + int'(st_b[c]) * WB + 128) / 256;
      if (y > M) y = M;
      case (md)
        3'd1: begin er = 0; eg = y; eb = 0; end
        3'd2: begin er = y; eg = y / 2; eb = 0; end
        3'd3: begin er = y; eg = y; eb = y; end
        3'd4: begin er = M - y; eg = M - y; eb = M - y; end
        default: begin er = int'(st_r[c]); eg = int'(st_g[c]); eb = int'(st_b[c]); end
      endcase
      if (sc && par) begin er = er / 2; eg = eg / 2; eb = eb / 2; end
      if (!st_de[c]) begin er = 0; eg = 0; eb = 0; end
      ex_rgb[c] = {6'(er), 6'(eg), 6'(eb)};
      ex_ma[c]  = {sc, md};
    end
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, st_m[0], st_s[0]); step();
    rst_n = 1'b1;
    for (int j = 0; j < len + 2; j++) begin
      if (j < len) drive(st_r[j], st_g[j], st_b[j], st_de[j], st_hs[j], st_vs[j], st_m[j], st_s[j]);
      else drive(0, 0, 0, 0, 0, 0, st_m[len-1], st_s[len-1]);
      step();
      if (j >= 2) begin
        n_cmp++; if ({r0, g0, b0} !== ex_rgb[j-2]) begin
          n_err++; $display("FAIL %s rgb0 idx=%0d got=%h exp=%h", name, j - 2, {r0, g0, b0}, ex_rgb[j-2]); end
        n_cmp++; if ({r1, g1, b1} !== ex_rgb[j-2]) begin
          n_err++; $display("FAIL %s rgb1 idx=%0d got=%h exp=%h", name, j - 2, {r1, g1, b1}, ex_rgb[j-2]); end
        n_cmp++; if ({hs0, vs0} !== {~st_hs[j-2], ~st_vs[j-2]}) begin
          n_err++; $display("FAIL %s sync0 idx=%0d got=%b exp=%b", name, j - 2, {hs0, vs0}, {~st_hs[j-2], ~st_vs[j-2]}); end
        n_cmp++; if ({hs1, vs1} !== {st_hs[j-2], st_vs[j-2]}) begin
          n_err++; $display("FAIL %s sync1 idx=%0d got=%b exp=%b", name, j - 2, {hs1, vs1}, {st_hs[j-2], st_vs[j-2]}); end
      end
      if (j >= 1 && j - 1 < len - 1) begin
        n_cmp++; if (m0 !== ex_ma[j-1] || m1 !== ex_ma[j-1]) begin
          n_err++; $display("FAIL %s mode_act idx=%0d got=%h/%h exp=%h", name, j - 1, m0, m1, ex_ma[j-1]); end
      end
    end
  endtask

  task automatic test_scanlines();
    int len = 220;
    for (int i = 0; i < len; i++) begin
      st_r[i] = 63; st_g[i] = 63; st_b[i] = 63;
      st_de[i] = ((i % 10) >= 2);
      st_hs[i] = ((i % 10) == 0);
      st_vs[i] = ((i % 50) < 2);
      st_m[i] = 3'd3; st_s[i] = 1'b1;
    end
    run_stream("scanlines", len);
  endtask

  task automatic test_blanking();
    int len = 160;
    for (int i = 0; i < len; i++) begin
      st_r[i] = 63; st_g[i] = 63; st_b[i] = 63;
      st_de[i] = ($urandom_range(0, 1) == 1);
      st_hs[i] = ($urandom_range(0, 3) == 0);
      st_vs[i] = ($urandom_range(0, 9) == 0);
      st_m[i] = 3'($urandom_range(0, 4)); st_s[i] = 1'($urandom_range(0, 1));
    end
    run_stream("blanking", len);
  endtask

  task automatic test_random(input string name);
    int len = 400;
    logic [2:0] cm;
    logic cs;
    cm = 3'($urandom_range(0, 7)); cs = 1'($urandom_range(0, 1));
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 7) == 0) cm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) cs = ~cs;
      st_r[i] = 6'($urandom); st_g[i] = 6'($urandom); st_b[i] = 6'($urandom);
      st_de[i] = ($urandom_range(0, 3) != 0);
      st_hs[i] = ($urandom_range(0, 5) == 0);
      st_vs[i] = ($urandom_range(0, 19) == 0);
      st_m[i] = cm; st_s[i] = cs;
    end
    // Coincident hs/vs leading edges.
    st_hs[49] = 0; st_vs[49] = 0; st_hs[50] = 1; st_vs[50] = 1;
    st_hs[199] = 0; st_vs[199] = 0; st_hs[200] = 1; st_vs[200] = 1;
    run_stream(name, len);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 3'd0, 1'b0);
    test_reset();
    test_tints();
    test_mode_midframe();
    test_reset_midline();
    test_scanlines();
    test_blanking();
    test_random("random_a");
    test_random("random_b");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
